// File: rtl/tensor_core.sv
// Signed SIZE x SIZE matrix multiply-accumulate D = A x B + C, one k-slice per clock.
// Latency: accept at edge E0, matrix_d/valid_out registered at edge E0+SIZE+1 (one-cycle pulse).
// No backpressure: valid_in is ignored while busy; requests are neither queued nor acknowledged.
module tensor_core #(
  parameter int DATA_WIDTH     = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int SIZE           = 4,
  parameter int CLOG2_SIZE_VAL = (SIZE > 1) ? $clog2(SIZE) : 0
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            valid_in,
  input  logic [7:0]                                      opcode,
  input  logic signed [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] matrix_a,
  input  logic signed [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] matrix_b,
  input  logic signed [SIZE-1:0][SIZE-1:0][ACC_WIDTH-1:0]  matrix_c,
  output logic                                            valid_out,
  output logic signed [SIZE-1:0][SIZE-1:0][ACC_WIDTH-1:0]  matrix_d
);

  // k counter needs at least one bit even for a 1x1 engine
  localparam int KW = (CLOG2_SIZE_VAL < 1) ? 1 : CLOG2_SIZE_VAL;
  localparam logic [KW-1:0] K_LAST = KW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t state, state_nxt;

  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] a_q;
  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] b_q;
  logic signed [ACC_WIDTH-1:0]               acc [SIZE][SIZE];
  logic [KW-1:0]                             k;

  // Full-precision signed product, then sign-extended or truncated to the accumulator width
  function automatic logic signed [ACC_WIDTH-1:0] prod(input logic signed [DATA_WIDTH-1:0] x,
                                                       input logic signed [DATA_WIDTH-1:0] y);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = x * y;
    return ACC_WIDTH'(p);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: accept in IDLE, run SIZE slices, then one cycle to publish the result
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in) state_nxt = COMPUTE;
      COMPUTE: if (k == K_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, accumulation and registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      k         <= '0;
      valid_out <= 1'b0;
      matrix_d  <= '0;
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          acc[i][j] <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            a_q <= matrix_a;
            b_q <= matrix_b;
            k   <= '0;
            // opcode 01 drops the addend; every other opcode accumulates onto C
            for (int i = 0; i < SIZE; i++)
              for (int j = 0; j < SIZE; j++)
                acc[i][j] <= (opcode == 8'h01) ? '0 : matrix_c[i][j];
          end
        end
        COMPUTE: begin
          for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
              acc[i][j] <= acc[i][j] + prod(a_q[i][k], b_q[k][j]);
          k <= k + 1'b1;
        end
        DONE: begin
          for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
              matrix_d[i][j] <= acc[i][j];
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core.sv
// Self-checking bench for tensor_core: scoreboard queue fed by stimulus, popped by a monitor.
// Latency is checked against the posedge count recorded at issue time.
// The DUT has no backpressure, so stimulus only issues once the previous result has been published.
module tb_tensor_core;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int N  = 4;

  typedef logic [N-1:0][N-1:0][DW-1:0] mat16_t;
  typedef logic [N-1:0][N-1:0][AW-1:0] mat32_t;
  typedef struct {
    mat32_t d;
    int     cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] opcode = 8'h00;
  mat16_t     ma = '0, mb = '0;
  mat32_t     mc = '0;
  logic       valid_out;
  mat32_t     md;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  tensor_core #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIZE(N)) dut (
    .clk(clk), .rst(rst_n), .valid_in(valid_in), .opcode(opcode),
    .matrix_a(ma), .matrix_b(mb), .matrix_c(mc),
    .valid_out(valid_out), .matrix_d(md)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mathematical D = [C] + A*B, reduced mod 2^AW at the end
  function automatic mat32_t model(input mat16_t a, input mat16_t b, input mat32_t c,
                                   input logic [7:0] op);
    mat32_t d;
    longint s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = (op == 8'h01) ? 64'sd0 : longint'($signed(c[i][j]));
        for (int k = 0; k < N; k++)
          s += longint'($signed(a[i][k])) * longint'($signed(b[k][j]));
        d[i][j] = s[AW-1:0];
      end
    return d;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid_out pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_out) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: valid_out=1 at cycle %0d with no operation outstanding", cyc);
        end else begin
          e = sb.pop_front();
          chk("latency", 512'(cyc), 512'(e.cyc));
          chk("result", 512'(md), 512'(e.d));
        end
      end
    end
  end

  // Drive one request at a negedge; inputs are scrambled after acceptance
  task automatic issue(input mat16_t a, input mat16_t b, input mat32_t c, input logic [7:0] op,
                       input bit expect_result);
    exp_t e;
    @(negedge clk);
    ma = a; mb = b; mc = c; opcode = op; valid_in = 1'b1;
    if (expect_result) begin
      e.d   = model(a, b, c, op);
      e.cyc = cyc + 6;
      sb.push_back(e);
    end
    @(negedge clk);
    valid_in = 1'b0;
    ma = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    mb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    opcode = 8'($urandom);
  endtask

  task automatic wait_done();
    repeat (N + 3) @(negedge clk);
  endtask

  function automatic mat16_t fill16(input logic [DW-1:0] v);
    mat16_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat32_t fill32(input logic [AW-1:0] v);
    mat32_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  initial begin
    mat16_t a, b, idm;
    mat32_t c, a_ext, exp1;
    int     v;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_valid_out", 512'(valid_out), 512'(0));
    chk("reset_matrix_d", 512'(md), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Identity: D == A
    a = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
         16'd9, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    idm = '0;
    for (int i = 0; i < N; i++) idm[i][i] = 16'd1;
    issue(a, idm, '0, 8'h00, 1'b1);
    wait_done();
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) a_ext[i][j] = AW'($signed(a[i][j]));
    chk("identity", 512'(md), 512'(a_ext));

    // Accumulate vs plain multiply
    issue(fill16(16'd2), fill16(16'd2), fill32(32'd7), 8'h00, 1'b1);
    wait_done();
    chk("acc_op00", 512'(md), 512'(fill32(32'd23)));
    issue(fill16(16'd2), fill16(16'd2), fill32(32'd7), 8'h01, 1'b1);
    wait_done();
    chk("mul_op01", 512'(md), 512'(fill32(32'd16)));
    issue(fill16(16'd2), fill16(16'd2), fill32(32'd7), 8'hA5, 1'b1);
    wait_done();
    chk("acc_opA5", 512'(md), 512'(fill32(32'd23)));

    // Wraparound
    issue(fill16(16'h7FFF), fill16(16'h7FFF), fill32(32'h7FFFFFFF), 8'h00, 1'b1);
    wait_done();
    chk("wrap", 512'(md), 512'(fill32(32'h7FFC0003)));

    // Randomized small operands, including negative results
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
        v = int'($urandom_range(0, 8)) - 4; a[i][j] = DW'(v);
        v = int'($urandom_range(0, 6)) - 3; b[i][j] = DW'(v);
        v = int'($urandom_range(0, 10)) - 5; c[i][j] = AW'(v);
      end
      issue(a, b, c, 8'h00, 1'b1);
      wait_done();
    end

    // Busy: a second request two cycles after accept is ignored
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      a[i][j] = DW'($urandom_range(0, 200));
      b[i][j] = DW'($urandom_range(0, 200));
      c[i][j] = AW'($urandom_range(0, 1000));
    end
    exp1 = model(a, b, c, 8'h00);
    issue(a, b, c, 8'h00, 1'b1);
    @(negedge clk);
    ma = fill16(16'd9); mb = fill16(16'd9); valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_done();
    for (int t = 0; t < 6; t++) begin
      chk("hold_valid_out", 512'(valid_out), 512'(0));
      chk("hold_matrix_d", 512'(md), 512'(exp1));
      @(negedge clk);
    end

    // Reset mid-operation
    issue(fill16(16'd3), fill16(16'd3), fill32(32'd1), 8'h00, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 512'(valid_out), 512'(0));
    chk("midrst_matrix_d", 512'(md), 512'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);
    chk("post_rst_quiet", 512'(md), 512'(0));
    issue(fill16(16'hFFFF), fill16(16'd5), fill32(32'd4), 8'h00, 1'b1);
    wait_done();
    chk("post_rst_op", 512'(md), 512'(fill32(32'hFFFFFFF0)));

    // Drain with a bounded wait
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", 512'(sb.size()), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
